// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART transmitter between
// several AXI-stream byte producers, with forced release of stalled owners.
module uart_tx_arbiter #(
  parameter int unsigned NUM_PORTS    = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned IDLE_TIMEOUT = 1023
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [NUM_PORTS-1:0]             grant,
  output logic                             timeout_pulse
);

  localparam int unsigned IDX_W      = $clog2(NUM_PORTS);
  localparam int unsigned CNT_W      = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned THRESH_INT = (IDLE_TIMEOUT > 0) ? (IDLE_TIMEOUT - 1) : 0;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(THRESH_INT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_e;

  state_e               state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [IDX_W-1:0]     gidx_q;
  logic [IDX_W-1:0]     last_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 timeout_q;

  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  xfer;
  logic                  timeout_hit;

  // First requester after the last owner, wrapping modulo NUM_PORTS.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((32'(last_q) + k) % NUM_PORTS);
      if (!sel_found && s_axis_tvalid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Grant is all-zero while idle, so the AND-OR mux also blanks the output.
  always_comb begin
    g_data = '0;
    for (int i = 0; i < int'(NUM_PORTS); i++) begin
      if (grant_q[i]) begin
        g_data = g_data | s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign g_valid       = |(s_axis_tvalid & grant_q);
  assign g_last        = |(s_axis_tlast & grant_q);
  assign m_axis_tdata  = g_data;
  assign m_axis_tvalid = g_valid;
  assign s_axis_tready = {NUM_PORTS{m_axis_tready}} & grant_q;
  assign xfer          = g_valid & m_axis_tready;
  assign timeout_hit   = (IDLE_TIMEOUT != 0) && !g_valid && (cnt_q == THRESH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      last_q    <= IDX_W'(NUM_PORTS - 1);
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sel_found) begin
            state_q <= S_LOCKED;
            grant_q <= NUM_PORTS'(1) << sel_idx;
            gidx_q  <= sel_idx;
            cnt_q   <= '0;
          end
        end
        S_LOCKED: begin
          if (xfer && g_last) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= gidx_q;
            cnt_q   <= '0;
          end else if (timeout_hit) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= gidx_q;
            cnt_q     <= '0;
            timeout_q <= 1'b1;
          end else if (g_valid) begin
            cnt_q <= '0;
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign grant         = grant_q;
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance with a 16-cycle timeout,
// one with the timeout disabled, both fed from the same producers.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] tdata;
  logic [3:0]  tvalid;
  logic [3:0]  tlast;
  logic        mready;

  logic [3:0]  tready16, grant16, tready0, grant0;
  logic [7:0]  mdata16, mdata0;
  logic        mvalid16, to16, mvalid0, to0;

  int checks = 0;
  int errors = 0;

  int         sent [4];
  int         plen [4];
  logic [3:0] order[$];
  logic [7:0] rx[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(8), .IDLE_TIMEOUT(16)) dut16 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(tready16),
    .m_axis_tdata(mdata16), .m_axis_tvalid(mvalid16), .m_axis_tready(mready),
    .grant(grant16), .timeout_pulse(to16)
  );

  uart_tx_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(8), .IDLE_TIMEOUT(0)) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .s_axis_tready(tready0),
    .m_axis_tdata(mdata0), .m_axis_tvalid(mvalid0), .m_axis_tready(mready),
    .grant(grant0), .timeout_pulse(to0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tdata  = '0;
    tvalid = '0;
    tlast  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    mready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Producers advance on their own tvalid & tready; records grant order and output bytes.
  task automatic run_traffic(input int max_cyc);
    logic [3:0] prev;
    bit         done;
    prev = '0;
    done = 1'b0;
    order.delete();
    rx.delete();
    for (int c = 0; c < max_cyc && !done; c++) begin
      done = 1'b1;
      for (int p = 0; p < 4; p++) if (sent[p] < plen[p]) done = 1'b0;
      if (!done) begin
        for (int p = 0; p < 4; p++) begin
          tvalid[p]        = (sent[p] < plen[p]);
          tdata[p*8 +: 8]  = 8'(p * 16 + sent[p]);
          tlast[p]         = (sent[p] == plen[p] - 1);
        end
        #1;
        if (grant16 != 4'b0 && grant16 != prev) order.push_back(grant16);
        prev = grant16;
        for (int p = 0; p < 4; p++) begin
          if (tvalid[p] && tready16[p]) begin
            rx.push_back(mdata16);
            sent[p]++;
          end
        end
        tick();
      end
    end
    idle_inputs();
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL traffic_done: packets still pending after %0d cycles", max_cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    tvalid = 4'b1111;
    mready = 1'b1;
    tick();
    tick();
    checks++; if (grant16 !== 4'b0) begin errors++; $display("FAIL reset_grant got %b exp %b", grant16, 4'b0); end
    checks++; if (to16 !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", to16); end
    checks++; if (mvalid16 !== 1'b0) begin errors++; $display("FAIL reset_mvalid got %b exp 0", mvalid16); end
    checks++; if (tready16 !== 4'b0) begin errors++; $display("FAIL reset_tready got %b exp 0000", tready16); end
    checks++; if (grant0 !== 4'b0) begin errors++; $display("FAIL reset_grant_nto got %b exp 0000", grant0); end
    idle_inputs();
    rst = 1'b1;
  endtask

  task automatic test_single_packet();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    do_reset();
    tvalid = 4'b0100;
    tdata[23:16] = exp_b[0];
    #1;
    checks++; if (grant16 !== 4'b0) begin errors++; $display("FAIL single_arb_latency got %b exp 0000", grant16); end
    checks++; if (mvalid16 !== 1'b0) begin errors++; $display("FAIL single_idle_mvalid got %b exp 0", mvalid16); end
    tick();
    for (int i = 0; i < 3; i++) begin
      tdata[23:16] = exp_b[i];
      tlast[2]     = (i == 2);
      #1;
      checks++; if (grant16 !== 4'b0100) begin errors++; $display("FAIL single_grant[%0d] got %b exp 0100", i, grant16); end
      checks++; if (mdata16 !== exp_b[i]) begin errors++; $display("FAIL single_data[%0d] got %h exp %h", i, mdata16, exp_b[i]); end
      checks++; if (mvalid16 !== 1'b1) begin errors++; $display("FAIL single_mvalid[%0d] got %b exp 1", i, mvalid16); end
      tick();
    end
    checks++; if (grant16 !== 4'b0) begin errors++; $display("FAIL single_release got %b exp 0000", grant16); end
    idle_inputs();
    #1;
    checks++; if (mvalid16 !== 1'b0) begin errors++; $display("FAIL single_after_mvalid got %b exp 0", mvalid16); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_o [3];
    logic [7:0] exp_rx [6];
    exp_o[0] = 4'b0001; exp_o[1] = 4'b0010; exp_o[2] = 4'b1000;
    exp_rx[0] = 8'h00; exp_rx[1] = 8'h01; exp_rx[2] = 8'h10;
    exp_rx[3] = 8'h11; exp_rx[4] = 8'h30; exp_rx[5] = 8'h31;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      plen[0] = 2; plen[1] = 2; plen[2] = 0; plen[3] = 2;
      for (int p = 0; p < 4; p++) sent[p] = 0;
      run_traffic(40);
      checks++;
      if (order.size() != 3) begin
        errors++; $display("FAIL rr_grant_count round %0d got %0d exp 3", r, order.size());
      end else begin
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (order[k] !== exp_o[k]) begin errors++; $display("FAIL rr_order round %0d slot %0d got %b exp %b", r, k, order[k], exp_o[k]); end
        end
      end
      checks++;
      if (rx.size() != 6) begin
        errors++; $display("FAIL rr_byte_count round %0d got %0d exp 6", r, rx.size());
      end else begin
        for (int k = 0; k < 6; k++) begin
          checks++;
          if (rx[k] !== exp_rx[k]) begin errors++; $display("FAIL rr_byte round %0d idx %0d got %h exp %h", r, k, rx[k], exp_rx[k]); end
        end
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    tvalid = 4'b0110;
    tdata[15:8]  = 8'h11;
    tdata[23:16] = 8'h22;
    tlast = 4'b0100;
    tick();
    checks++; if (grant16 !== 4'b0010) begin errors++; $display("FAIL to_first_grant got %b exp 0010", grant16); end
    checks++; if (mdata16 !== 8'h11) begin errors++; $display("FAIL to_first_data got %h exp 11", mdata16); end
    tick();
    tvalid[1] = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      checks++;
      if (grant16 !== 4'b0010 || to16 !== 1'b0) begin
        errors++; $display("FAIL to_hold cycle %0d grant %b pulse %b exp 0010/0", k, grant16, to16);
      end
    end
    tick();
    checks++; if (to16 !== 1'b1) begin errors++; $display("FAIL to_pulse got %b exp 1", to16); end
    checks++; if (grant16 !== 4'b0) begin errors++; $display("FAIL to_release got %b exp 0000", grant16); end
    checks++; if (mvalid16 !== 1'b0) begin errors++; $display("FAIL to_release_mvalid got %b exp 0", mvalid16); end
    tick();
    checks++; if (to16 !== 1'b0) begin errors++; $display("FAIL to_pulse_width got %b exp 0", to16); end
    checks++; if (grant16 !== 4'b0100) begin errors++; $display("FAIL to_next_grant got %b exp 0100", grant16); end
    checks++; if (mdata16 !== 8'h22) begin errors++; $display("FAIL to_next_data got %h exp 22", mdata16); end
    tick();
    idle_inputs();
  endtask

  task automatic test_tready_toggle();
    int s0;
    logic [7:0] got [$];
    s0 = 0;
    do_reset();
    for (int c = 0; c < 60 && s0 < 4; c++) begin
      mready       = 1'(((c / 3) % 2));
      tvalid[0]    = 1'b1;
      tdata[7:0]   = 8'(8'hA0 + s0);
      tlast[0]     = (s0 == 3);
      tvalid[2]    = 1'b1;
      tdata[23:16] = 8'h55;
      tlast[2]     = 1'b1;
      #1;
      if (grant16[0]) begin
        checks++; if (tready16[0] !== mready) begin errors++; $display("FAIL tog_tready0 cyc %0d got %b exp %b", c, tready16[0], mready); end
        checks++; if (tready16[3:1] !== 3'b0) begin errors++; $display("FAIL tog_tready_other cyc %0d got %b exp 000", c, tready16[3:1]); end
        checks++; if (mdata16 !== 8'(8'hA0 + s0)) begin errors++; $display("FAIL tog_data cyc %0d got %h exp %h", c, mdata16, 8'(8'hA0 + s0)); end
      end
      if (tvalid[0] && tready16[0]) begin
        got.push_back(mdata16);
        s0++;
      end
      tick();
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL tog_byte_count got %0d exp 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got[k] !== 8'(8'hA0 + k)) begin errors++; $display("FAIL tog_byte idx %0d got %h exp %h", k, got[k], 8'(8'hA0 + k)); end
      end
    end
    mready = 1'b1;
    idle_inputs();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    tvalid = 4'b1000;
    tdata[31:24] = 8'hD0;
    tick();
    checks++; if (grant16 !== 4'b1000) begin errors++; $display("FAIL rmp_grant got %b exp 1000", grant16); end
    tick();
    tdata[31:24] = 8'hD1;
    tdata[7:0]   = 8'h0A;
    tvalid = 4'b1001;
    rst = 1'b0;
    tick();
    checks++; if (grant16 !== 4'b0) begin errors++; $display("FAIL rmp_grant_drop got %b exp 0000", grant16); end
    checks++; if (mvalid16 !== 1'b0) begin errors++; $display("FAIL rmp_mvalid got %b exp 0", mvalid16); end
    checks++; if (to16 !== 1'b0) begin errors++; $display("FAIL rmp_pulse got %b exp 0", to16); end
    checks++; if (tready16 !== 4'b0) begin errors++; $display("FAIL rmp_tready got %b exp 0000", tready16); end
    rst = 1'b1;
    tick();
    checks++; if (grant16 !== 4'b0001) begin errors++; $display("FAIL rmp_port0_wins got %b exp 0001", grant16); end
    checks++; if (mdata16 !== 8'h0A) begin errors++; $display("FAIL rmp_data got %h exp 0a", mdata16); end
    idle_inputs();
  endtask

  task automatic test_no_timeout();
    int bad;
    bad = 0;
    do_reset();
    tvalid = 4'b0001;
    tdata[7:0] = 8'h61;
    tick();
    checks++; if (grant0 !== 4'b0001) begin errors++; $display("FAIL nto_grant got %b exp 0001", grant0); end
    tick();
    tvalid = 4'b0;
    for (int k = 0; k < 5000; k++) begin
      tick();
      if (grant0 !== 4'b0001 || to0 !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL nto_hold bad_cycles %0d exp 0", bad); end
    tvalid = 4'b0001;
    tdata[7:0] = 8'h62;
    tlast = 4'b0001;
    #1;
    checks++; if (mdata0 !== 8'h62) begin errors++; $display("FAIL nto_data got %h exp 62", mdata0); end
    checks++; if (mvalid0 !== 1'b1) begin errors++; $display("FAIL nto_mvalid got %b exp 1", mvalid0); end
    tick();
    checks++; if (grant0 !== 4'b0) begin errors++; $display("FAIL nto_release got %b exp 0000", grant0); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    mready = 1'b1;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_timeout();
    test_tready_toggle();
    test_reset_mid_packet();
    test_no_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
